// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - pushbutton synchronizer, debouncer and press-pulse FSM
// Define KEY_COND_AUTOREPEAT_EN to add hold-to-repeat pulses.
module key_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 8,
   parameter int REPEAT_CYCLES   = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic level,
   output logic pulse
);

   localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] RELEASED = 2'd0;
   localparam logic [1:0] HELD     = 2'd1;

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;
   logic [1:0]    state;
   logic          rise;
   logic          fall;

   // Inverted so that s2 = 1 means pressed.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= ~key_n;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (s2 == level) begin
         cnt <= '0;
      end else if (cnt == DB_LAST) begin
         level <= ~level;
         cnt   <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign rise = s2 & ~level & (cnt == DB_LAST);
   assign fall = ~s2 & level & (cnt == DB_LAST);

`ifdef KEY_COND_AUTOREPEAT_EN
   localparam logic [1:0]    REPEAT    = 2'd2;
   localparam int            RMAX      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int            RW        = $clog2(RMAX + 1);
   localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rcnt;

   // A falling level wins over a repeat due on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RELEASED;
         pulse <= 1'b0;
         rcnt  <= '0;
      end else begin
         pulse <= 1'b0;
         case (state)
            RELEASED: begin
               if (rise) begin
                  state <= HELD;
                  pulse <= 1'b1;
                  rcnt  <= '0;
               end
            end
            HELD: begin
               if (fall) begin
                  state <= RELEASED;
                  rcnt  <= '0;
               end else if (rcnt == HOLD_LAST) begin
                  state <= REPEAT;
                  pulse <= 1'b1;
                  rcnt  <= '0;
               end else begin
                  rcnt <= rcnt + 1'b1;
               end
            end
            REPEAT: begin
               if (fall) begin
                  state <= RELEASED;
                  rcnt  <= '0;
               end else if (rcnt == REP_LAST) begin
                  pulse <= 1'b1;
                  rcnt  <= '0;
               end else begin
                  rcnt <= rcnt + 1'b1;
               end
            end
            default: begin
               state <= RELEASED;
               rcnt  <= '0;
            end
         endcase
      end
   end
`else
   localparam int unused_params = HOLD_CYCLES + REPEAT_CYCLES;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RELEASED;
         pulse <= 1'b0;
      end else begin
         pulse <= 1'b0;
         case (state)
            RELEASED: begin
               if (rise) begin
                  state <= HELD;
                  pulse <= 1'b1;
               end
            end
            HELD: begin
               if (fall) state <= RELEASED;
            end
            default: state <= RELEASED;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - scoreboard bench for key_conditioner
// Define KEY_COND_AUTOREPEAT_EN to check the hold-to-repeat build.
module tb_key_conditioner;

   localparam int DB   = 4;
   localparam int HOLD = 8;
   localparam int REP  = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic key_n = 1'b1;
   logic level;
   logic pulse;

   int n_checks = 0;
   int n_fail = 0;

   logic [1:0] exp_q[$];

   // Reference state: delayed pressed samples, run length, press age.
   logic m_d0 = 1'b0;
   logic m_d1 = 1'b0;
   logic m_level = 1'b0;
   logic m_pulse = 1'b0;
   int   m_run = 0;
   int   m_age = 0;

   key_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .HOLD_CYCLES(HOLD),
      .REPEAT_CYCLES(REP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .key_n(key_n),
      .level(level),
      .pulse(pulse)
   );

   always #5 clk = ~clk;

   task automatic step(input logic r, input logic k);
      logic v;
      logic was_high;
      @(negedge clk);
      reset = r;
      key_n = k;
      if (r) begin
         m_d0 = 1'b0;
         m_d1 = 1'b0;
         m_level = 1'b0;
         m_run = 0;
         m_age = 0;
         m_pulse = 1'b0;
      end else begin
         v = m_d1;
         m_d1 = m_d0;
         m_d0 = ~k;
         was_high = m_level;
         m_pulse = 1'b0;
         if (v == m_level) begin
            m_run = 0;
         end else begin
            m_run++;
            if (m_run == DB) begin
               m_level = v;
               m_run = 0;
               if (v) begin
                  m_pulse = 1'b1;
                  m_age = 0;
               end
            end
         end
`ifdef KEY_COND_AUTOREPEAT_EN
         if (was_high && m_level) begin
            m_age++;
            if (m_age == HOLD || (m_age > HOLD && (m_age - HOLD) % REP == 0))
               m_pulse = 1'b1;
         end
`else
         if (was_high && m_level) m_age++;
`endif
      end
      exp_q.push_back({m_level, m_pulse});
   endtask

   task automatic hold(input logic r, input logic k, input int n);
      for (int i = 0; i < n; i++) step(r, k);
   endtask

   // Monitor: one expected entry per clock edge after stimulus begins.
   initial begin
      logic [1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (level !== e[1]) begin
               n_fail++;
               $display("FAIL level: got %0b expected %0b at %0t", level, e[1], $time);
            end
            n_checks++;
            if (pulse !== e[0]) begin
               n_fail++;
               $display("FAIL pulse: got %0b expected %0b at %0t", pulse, e[0], $time);
            end
         end
      end
   end

   initial begin
      int n;
      logic k;
      // reset then idle
      hold(1'b1, 1'b1, 2);
      hold(1'b0, 1'b1, 20);
      // single press and release
      hold(1'b0, 1'b0, 15);
      hold(1'b0, 1'b1, 15);
      // bouncing key
      for (int i = 0; i < 5; i++) begin
         hold(1'b0, 1'b0, 2);
         hold(1'b0, 1'b1, 2);
      end
      hold(1'b0, 1'b1, 10);
      // reset mid-debounce with key held
      hold(1'b0, 1'b0, 4);
      hold(1'b1, 1'b0, 1);
      hold(1'b0, 1'b0, 12);
      hold(1'b0, 1'b1, 10);
      // back-to-back press / release / press at the minimum stable time
      hold(1'b0, 1'b0, DB);
      hold(1'b0, 1'b1, DB);
      hold(1'b0, 1'b0, DB);
      hold(1'b0, 1'b1, 10);
      // long holds for autorepeat and restart of the hold delay
      hold(1'b0, 1'b0, 30);
      hold(1'b0, 1'b1, 10);
      hold(1'b0, 1'b0, 25);
      hold(1'b1, 1'b0, 1);
      hold(1'b0, 1'b0, 20);
      hold(1'b0, 1'b1, 10);
      // random segments with occasional reset
      for (int i = 0; i < 300; i++) begin
         k = 1'($urandom_range(0, 1));
         n = $urandom_range(1, 14);
         if ($urandom_range(0, 40) == 0) hold(1'b1, k, 1);
         else hold(1'b0, k, n);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 4, sets the number of consecutive stable synchronized samples needed to change the debounced level; legal range is 1 to 2^20.
- REQ-002: Parameter HOLD_CYCLES, default 8, sets the delay from the press pulse to the first autorepeat pulse; it is used only with KEY_COND_AUTOREPEAT_EN and must be at least 2.
- REQ-003: Parameter REPEAT_CYCLES, default 3, sets the period between autorepeat pulses; it is used only with KEY_COND_AUTOREPEAT_EN and must be at least 1.
- REQ-004: clk, input, 1 bit, the single system clock; all flops SHALL use its rising edge.
- REQ-005: reset, input, 1 bit, synchronous active-high reset.
- REQ-006: key_n, input, 1 bit, raw asynchronous pushbutton where 0 means pressed.
- REQ-007: level, output, 1 bit, registered debounced pressed state where 1 means held.
- REQ-008: pulse, output, 1 bit, registered one-cycle strobe that drives the downstream FSM input w.

Function
- REQ-009: key_n SHALL pass through a two-flop synchronizer, inverted, to give the internal signal s2 (1 = pressed); both flops SHALL reset to 0.
- REQ-010: The debounce counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and obey these rules each cycle:
  - if s2 equals level, the counter clears to 0;
  - if s2 differs from level and the counter is below DEBOUNCE_CYCLES-1, the counter increments;
  - if s2 differs from level and the counter equals DEBOUNCE_CYCLES-1, level toggles and the counter clears.
- REQ-011: Latency: level SHALL change at the (2+DEBOUNCE_CYCLES)th rising edge after the first edge that samples the new key_n value, provided key_n stays stable.
- REQ-012: If key_n reverts within fewer than DEBOUNCE_CYCLES s2 samples (a bounce), level SHALL NOT change, and counting restarts from 0 on the next difference.
- REQ-013: The press FSM SHALL have states RELEASED and HELD, with reset state RELEASED:
  - RELEASED goes to HELD on the edge where level rises;
  - HELD goes to RELEASED on the edge where level falls.
- REQ-014: pulse SHALL be 1 for exactly the one cycle registered on the same edge that level rises, and 0 otherwise, apart from REQ-020.
- REQ-015: A release (level falling) SHALL never generate a pulse.
- REQ-016: Back-to-back press, release and press, each stable for DEBOUNCE_CYCLES, SHALL produce two separate pulses.

Reset
- REQ-017: While reset is 1 at a clock edge, the following SHALL be cleared on that edge: sync flops, debounce counter, level, pulse, the FSM (to RELEASED), and the repeat counters.
- REQ-018: Reset asserted mid-count or mid-hold SHALL discard all progress, with no pulse during or on exit from reset.
- REQ-019: If the key is held through reset, it SHALL be treated as a new press, with pulse at edge 2+DEBOUNCE_CYCLES after reset deasserts.

Configuration
- REQ-020: With macro KEY_COND_AUTOREPEAT_EN defined, autorepeat SHALL operate as follows, and only while level stays 1:
  - the FSM adds state REPEAT and a hold/repeat counter of $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1) bits;
  - with the press pulse at edge E, extra one-cycle pulses occur at E+HOLD_CYCLES, then at E+HOLD_CYCLES+k*REPEAT_CYCLES for k = 1, 2, ...;
  - HELD goes to REPEAT at the first repeat pulse;
  - both HELD and REPEAT go to RELEASED on level falling, which clears the counter.
- REQ-021: Without KEY_COND_AUTOREPEAT_EN:
  - HOLD_CYCLES and REPEAT_CYCLES SHALL be ignored;
  - no REPEAT state or repeat counter SHALL be synthesized;
  - exactly one pulse SHALL occur per press.

Verification (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3)
- REQ-022: Reset for 2 cycles with key_n=1, then idle 20 cycles: level=0 and pulse=0 throughout.
- REQ-023: key_n drops to 0 before edge 1 and is held: level=1 from edge 6, pulse=1 only in the edge-6 cycle. Releasing the key gives level=0 six edges later, with no pulse.
- REQ-024: key_n toggles 0/1 every 2 cycles for 20 cycles, then settles at 1: level never rises and pulse stays 0.
- REQ-025: Key held, reset asserted for 1 cycle at edge 4 of debounce, then deasserted with the key still held: no pulse before reset, then a pulse exactly 6 edges after reset deasserts.
- REQ-026: With KEY_COND_AUTOREPEAT_EN, press pulse at edge E and key held 20 more cycles: pulses at E, E+8, E+11, E+14, E+17, E+20. Release stops pulses, and a subsequent press restarts the 8-cycle hold.
